clock_tick_selector: RTL and testbench



---
 rtl/clock_tick_selector.sv | 133 +++++++++++++
 tb/tb_clock_tick_selector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clock_tick_selector.sv
`default_nettype none
// ============================================================================
// Module   : clock_tick_selector
// Brief    : Selects one divided rate, re-times it as clk_out plus a tick
//            enable, and switches rate only at the common /16 boundary.
// Revision : 1.0 - initial release
// ============================================================================
module clock_tick_selector #(
  parameter logic [1:0] RESET_SEL = 2'd0,
  parameter int         TIMEOUT   = 64,
  parameter int         TCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              divideby2,
  input  logic              divideby4,
  input  logic              divideby8,
  input  logic              divideby16,
  input  logic              sel_req,
  input  logic [1:0]        sel_in,
  output logic              sel_busy,
  output logic              sel_done,
  output logic [1:0]        active_sel,
  output logic              clk_out,
  output logic              tick,
  output logic              stall,
  output logic [TCNT_W-1:0] tick_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [7:0]        C_TIMEOUT  = 8'(TIMEOUT);
  localparam logic [TCNT_W-1:0] C_TCNT_ONE = {{(TCNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [1:0]        r_active_sel;
  logic [1:0]        r_pend_sel;
  logic              r_d16_q;
  logic              r_clk_out;
  logic              r_tick;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_wdog;
  logic [TCNT_W-1:0] r_tick_cnt;

  logic w_div_sel;
  logic w_boundary;
  logic w_same_req;
  logic w_new_req;
  logic w_switch;
  logic w_done_set;

  always_comb begin
    w_div_sel = divideby2;
    case (r_active_sel)
      2'd0: w_div_sel = divideby2;
      2'd1: w_div_sel = divideby4;
      2'd2: w_div_sel = divideby8;
      2'd3: w_div_sel = divideby16;
      default: w_div_sel = divideby2;
    endcase
  end

  // Falling edge of /16: every divider output is low in this cycle.
  assign w_boundary = r_d16_q & ~divideby16;
  assign w_same_req = (r_state == ST_IDLE) & sel_req & (sel_in == r_active_sel);
  assign w_new_req  = (r_state == ST_IDLE) & sel_req & (sel_in != r_active_sel);
  assign w_switch   = (r_state == ST_PENDING) & w_boundary;
  assign w_done_set = w_same_req | w_switch;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_active_sel <= RESET_SEL;
      r_pend_sel   <= 2'd0;
      r_d16_q      <= 1'b0;
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wdog       <= 8'd0;
      r_tick_cnt   <= '0;
    end else begin
      r_d16_q   <= divideby16;
      r_clk_out <= w_div_sel;
      r_tick    <= w_div_sel & ~r_clk_out;
      r_done    <= w_done_set;

      case (r_state)
        ST_IDLE: begin
          if (w_new_req) begin
            r_pend_sel <= sel_in;
            r_busy     <= 1'b1;
            r_state    <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (w_boundary) begin
            r_active_sel <= r_pend_sel;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_done_set) begin
        r_tick_cnt <= '0;
      end else if (r_tick) begin
        r_tick_cnt <= r_tick_cnt + C_TCNT_ONE;
      end

      if (w_done_set || (w_div_sel != r_clk_out)) begin
        r_wdog <= 8'd0;
      end else if (r_wdog != C_TIMEOUT) begin
        r_wdog <= r_wdog + 8'd1;
      end
    end
  end

  assign sel_busy   = r_busy;
  assign sel_done   = r_done;
  assign active_sel = r_active_sel;
  assign clk_out    = r_clk_out;
  assign tick       = r_tick;
  assign stall      = (r_wdog == C_TIMEOUT);
  assign tick_cnt   = r_tick_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clock_tick_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_tick_selector
// Brief    : Directed self-checking bench for clock_tick_selector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_tick_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [3:0]  r_div_cnt = 4'd0;
  logic        divideby2, divideby4, divideby8, divideby16;
  logic        sel_req;
  logic [1:0]  sel_in;
  logic        sel_busy, sel_done, clk_out, tick, stall;
  logic [1:0]  active_sel;
  logic [15:0] tick_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Free-running divider model; run=0 forces all outputs low.
  always @(posedge clk) r_div_cnt <= r_div_cnt + 4'd1;
  assign divideby2  = run & r_div_cnt[0];
  assign divideby4  = run & r_div_cnt[1];
  assign divideby8  = run & r_div_cnt[2];
  assign divideby16 = run & r_div_cnt[3];

  clock_tick_selector #(
    .RESET_SEL (2'd0),
    .TIMEOUT   (64),
    .TCNT_W    (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .divideby2  (divideby2),
    .divideby4  (divideby4),
    .divideby8  (divideby8),
    .divideby16 (divideby16),
    .sel_req    (sel_req),
    .sel_in     (sel_in),
    .sel_busy   (sel_busy),
    .sel_done   (sel_done),
    .active_sel (active_sel),
    .clk_out    (clk_out),
    .tick       (tick),
    .stall      (stall),
    .tick_cnt   (tick_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Length of the clk_out run at level lvl, starting at the current cycle.
  task automatic measure_run(input logic lvl, output int n);
    n = 0;
    while (clk_out == lvl && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int lat;
    int n;

    rst = 1'b0; run = 1'b1; sel_req = 1'b0; sel_in = 2'd0;

    // Reset and default /2 operation
    repeat (3) @(negedge clk);
    check_eq("rst_clk_out",  32'(clk_out),    0);
    check_eq("rst_tick",     32'(tick),       0);
    check_eq("rst_busy",     32'(sel_busy),   0);
    check_eq("rst_done",     32'(sel_done),   0);
    check_eq("rst_stall",    32'(stall),      0);
    check_eq("rst_tick_cnt", 32'(tick_cnt),   0);
    check_eq("rst_active",   32'(active_sel), 0);
    if (!r_div_cnt[0]) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (clk_out !== k[0] || tick !== k[0]) bad++;
      if (k == 5) check_eq("tick_cnt_5", 32'(tick_cnt), 2);
    end
    check_eq("div2_toggle_bad", bad, 0);
    check_eq("tick_cnt_20", 32'(tick_cnt), 10);

    // Rate change to /16 with an ignored request while pending
    n = 0;
    while (r_div_cnt != 4'd5 && n < 20) begin @(negedge clk); n++; end
    sel_req = 1'b1; sel_in = 2'd3;
    @(negedge clk); lat = 1;
    sel_req = 1'b0; sel_in = 2'd0;
    check_eq("chg_busy", 32'(sel_busy), 1);
    check_eq("chg_no_done", 32'(sel_done), 0);
    repeat (2) begin @(negedge clk); lat++; end
    sel_req = 1'b1; sel_in = 2'd1;
    @(negedge clk); lat++;
    sel_req = 1'b0; sel_in = 2'd0;
    check_eq("busy_hold", 32'(sel_busy), 1);
    while (!sel_done && lat < 40) begin @(negedge clk); lat++; end
    check_eq("chg_latency", lat, 12);
    check_eq("chg_active", 32'(active_sel), 3);
    check_eq("chg_tick_cnt", 32'(tick_cnt), 0);
    check_eq("chg_busy_clr", 32'(sel_busy), 0);
    measure_run(1'b0, n);
    check_eq("d16_low_first", n, 8);
    check_eq("tick_at_rise", 32'(tick), 1);
    measure_run(1'b1, n);
    check_eq("d16_high", n, 8);
    check_eq("tick_cnt_after_rise", 32'(tick_cnt), 1);
    measure_run(1'b0, n);
    check_eq("d16_low", n, 8);

    // Same-select request completes immediately
    sel_req = 1'b1; sel_in = 2'd3;
    @(negedge clk);
    sel_req = 1'b0; sel_in = 2'd0;
    check_eq("same_done", 32'(sel_done), 1);
    check_eq("same_busy", 32'(sel_busy), 0);
    check_eq("same_tick_cnt", 32'(tick_cnt), 0);
    check_eq("same_active", 32'(active_sel), 3);
    @(negedge clk);
    check_eq("same_done_pulse", 32'(sel_done), 0);

    // Reset while pending discards the request
    sel_req = 1'b1; sel_in = 2'd2;
    @(negedge clk);
    sel_req = 1'b0; sel_in = 2'd0;
    check_eq("mid_busy", 32'(sel_busy), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_active", 32'(active_sel), 0);
    check_eq("mid_rst_busy", 32'(sel_busy), 0);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sel_done !== 1'b0 || active_sel !== 2'd0 || sel_busy !== 1'b0) bad++;
    end
    check_eq("mid_rst_no_done", bad, 0);

    // Stall watchdog with the divider held low
    run = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (63) @(negedge clk);
    check_eq("stall_63", 32'(stall), 0);
    @(negedge clk);
    check_eq("stall_64", 32'(stall), 1);
    if (!r_div_cnt[0]) @(negedge clk);
    check_eq("stall_hold", 32'(stall), 1);
    run = 1'b1;
    @(negedge clk);
    check_eq("stall_clear", 32'(stall), 0);
    check_eq("stall_clk_out", 32'(clk_out), 1);

    // Request in the boundary cycle waits for the following boundary
    repeat (17) @(negedge clk);
    n = 0;
    while (r_div_cnt != 4'd0 && n < 20) begin @(negedge clk); n++; end
    sel_req = 1'b1; sel_in = 2'd2;
    @(negedge clk); lat = 1;
    sel_req = 1'b0; sel_in = 2'd0;
    while (!sel_done && lat < 40) begin @(negedge clk); lat++; end
    check_eq("sim_latency", lat, 17);
    check_eq("sim_active", 32'(active_sel), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
